dmem_host_loader: RTL and testbench
===================================

Name: dmem_host_loader

Overview:
- Host-side counterpart to the core's data-memory interface. The core consumes data memory; this block fills it and drains it.
- Holds the core in reset and streams a block of input bytes into data memory (dmem).
- Releases the core, waits for its done flag or a timeout, then re-holds the core and streams a result window back out to the host.
- Sits beside the core in the top level. Top muxes the dmem write/address/data port to this block whenever core_rst=1.

Parameters:
- LOAD_BASE, 8'h00, first dmem address written during load.
- LOAD_LEN, 64, number of bytes loaded (0..256).
- DUMP_BASE, 8'h40, first dmem address read during dump.
- DUMP_LEN, 64, number of bytes dumped (0..256).
- TIMEOUT, 16'd10000, maximum RUN cycles; 0 disables the timeout.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load/run/dump sequence.
- in_data  input  8  host byte to load.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  8  dumped byte.
- out_valid  output  1  out_data valid.
- out_ready  input  1  host accepts out_data.
- core_rst  output  1  reset to the core; high except in RUN.
- core_done  input  1  core's done flag.
- dm_we  output  1  dmem write enable.
- dm_adr  output  8  dmem address.
- dm_di  output  8  dmem write data.
- dm_dout  input  8  dmem read data; combinational on dm_adr.
- busy  output  1  high in LOAD, RUN or DUMP.
- finished  output  1  sticky; sequence complete.
- timeout  output  1  sticky; RUN ended by timeout.

Behaviour:
- Reset (synchronous, any state) → state IDLE; cnt=0; cyc=0; core_rst=1; in_ready=0; out_valid=0; dm_we=0; dm_adr=0; dm_di=0; busy=0; finished=0; timeout=0. dmem contents are untouched.
- State machine: IDLE → LOAD → RUN → DUMP → FINISH. start is honoured only in IDLE or FINISH; elsewhere it is ignored.
- Taking start clears finished, timeout, cnt and cyc.
- From start:
  - LOAD_LEN>0 → LOAD.
  - LOAD_LEN=0 and DUMP_LEN>0 → RUN.
  - Both zero → RUN; an empty dump then goes straight to FINISH.
- LOAD:
  - in_ready=1.
  - Combinational write each cycle in_valid=1: dm_we=1, dm_adr=(LOAD_BASE+cnt) mod 256, dm_di=in_data.
  - cnt increments on each accepted beat; no write when in_valid=0.
  - Beat with cnt==LOAD_LEN-1 accepted → RUN next cycle, cnt=0.
- RUN:
  - core_rst is registered, so it is 0 from the first RUN cycle.
  - dm_we=0; the block does not drive the dmem port.
  - cyc increments every RUN cycle.
  - core_done=1 → DUMP next cycle.
  - Otherwise, TIMEOUT≠0 and cyc==TIMEOUT-1 → timeout=1, DUMP next cycle.
  - core_done and the timeout condition in the same cycle: done wins, timeout stays 0.
  - DUMP_LEN=0 → FINISH instead of DUMP.
- DUMP:
  - core_rst=1 and dm_we=0.
  - dm_adr=(DUMP_BASE+cnt) mod 256; out_valid=1; out_data=dm_dout, combinational.
  - dm_adr is held while out_ready=0, so out_data stays stable during a stall.
  - On out_valid&out_ready, cnt increments.
  - Beat with cnt==DUMP_LEN-1 accepted → FINISH.
- FINISH: finished=1, core_rst=1, busy=0; the state holds until start.
- Widths:
  - cnt is 9 bits, so length 256 is legal.
  - Address arithmetic is 8-bit and wraps modulo 256.
  - cyc is 16 bits.
- Throughput: one byte per cycle in LOAD and in DUMP when the host never stalls.

Test Plan:
- Load: LOAD_BASE=00, LOAD_LEN=4; bytes 11,22,33,44 with idle gaps between beats → exactly 4 writes: 00=11, 01=22, 02=33, 03=44; dm_we=0 in gap cycles; core_rst=0 in the cycle after the 4th beat.
- Run and dump: core_done pulses after 10 RUN cycles; DUMP_BASE=80, DUMP_LEN=2, dmem 80=AA, 81=BB; out_ready alternates 0/1 → host sees AA then BB, each once; out_data held during stalls; finished=1, busy=0, timeout=0.
- Timeout: TIMEOUT=20, core_done held 0 → DUMP entered after exactly 20 RUN cycles; timeout=1; core_rst=1 from the DUMP cycle.
- Simultaneous events: TIMEOUT=20, core_done=1 in RUN cycle 20 → DUMP entered with timeout=0.
- Wrap: LOAD_BASE=FE, LOAD_LEN=4 → write addresses FE, FF, 00, 01.
- Reset mid-operation: reset after 2 LOAD beats → next cycle IDLE with all outputs at reset values; a new start reloads from cnt=0 at LOAD_BASE.

Source files
------------

// File: rtl/dmem_host_loader.sv
// Host-side data-memory loader: holds the core in reset, fills dmem from the host,
// runs the core until done or timeout, then streams a result window back out.
module dmem_host_loader #(
  parameter logic [7:0]  LOAD_BASE = 8'h00,
  parameter int unsigned LOAD_LEN  = 32'd64,
  parameter logic [7:0]  DUMP_BASE = 8'h40,
  parameter int unsigned DUMP_LEN  = 32'd64,
  parameter logic [15:0] TIMEOUT   = 16'd10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       core_rst,
  input  logic       core_done,
  output logic       dm_we,
  output logic [7:0] dm_adr,
  output logic [7:0] dm_di,
  input  logic [7:0] dm_dout,
  output logic       busy,
  output logic       finished,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_DUMP   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  localparam logic        LOAD_EN   = (LOAD_LEN != 32'd0);
  localparam logic        DUMP_EN   = (DUMP_LEN != 32'd0);
  localparam logic        TO_EN     = (TIMEOUT != 16'd0);
  localparam logic [8:0]  LOAD_LAST = 9'(LOAD_LEN - 32'd1);
  localparam logic [8:0]  DUMP_LAST = 9'(DUMP_LEN - 32'd1);
  localparam logic [15:0] TO_LAST   = TIMEOUT - 16'd1;
  localparam state_t      RUN_EXIT  = DUMP_EN ? S_DUMP : S_FINISH;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [15:0] cyc_q, cyc_d;
  logic        core_rst_q, core_rst_d;
  logic        busy_q, busy_d;
  logic        finished_q, finished_d;
  logic        timeout_q, timeout_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;

  // Next-state, counters and the registered status outputs derived from the next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_FINISH: begin
        if (start) begin
          cnt_d     = 9'd0;
          cyc_d     = 16'd0;
          timeout_d = 1'b0;
          state_d   = LOAD_EN ? S_LOAD : S_RUN;
        end else begin
          state_d = state_q;
        end
      end
      S_LOAD: begin
        if (in_valid && (cnt_q == LOAD_LAST)) begin
          cnt_d   = 9'd0;
          state_d = S_RUN;
        end else if (in_valid) begin
          cnt_d = cnt_q + 9'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        cyc_d = cyc_q + 16'd1;
        // A done flag in the same cycle as the timeout wins; timeout stays clear.
        if (core_done) begin
          state_d = RUN_EXIT;
        end else if (TO_EN && (cyc_q == TO_LAST)) begin
          timeout_d = 1'b1;
          state_d   = RUN_EXIT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DUMP: begin
        if (out_ready && (cnt_q == DUMP_LAST)) begin
          state_d = S_FINISH;
        end else if (out_ready) begin
          cnt_d = cnt_q + 9'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    core_rst_d  = (state_d != S_RUN);
    busy_d      = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_DUMP);
    finished_d  = (state_d == S_FINISH);
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_DUMP);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 9'd0;
      cyc_q       <= 16'd0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timeout_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      timeout_q   <= timeout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // dmem port: same-cycle write in LOAD, address-only read in DUMP, idle otherwise.
  always_comb begin
    dm_we  = 1'b0;
    dm_adr = 8'h00;
    dm_di  = 8'h00;
    case (state_q)
      S_LOAD: begin
        dm_we  = in_valid;
        dm_adr = LOAD_BASE + cnt_q[7:0];
        dm_di  = in_valid ? in_data : 8'h00;
      end
      S_DUMP: begin
        dm_adr = DUMP_BASE + cnt_q[7:0];
      end
      default: begin
        dm_we  = 1'b0;
        dm_adr = 8'h00;
        dm_di  = 8'h00;
      end
    endcase
  end

  assign out_data  = dm_dout;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign core_rst  = core_rst_q;
  assign busy      = busy_q;
  assign finished  = finished_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_dmem_host_loader.sv
// Directed bench for dmem_host_loader: three instances cover the normal sequence,
// address wrap with timeout disabled, and the zero-length load/dump path.
module tb_dmem_host_loader;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready, core_done;
  logic [7:0] in_data;
  logic       start_a, start_b, start_c;

  logic       in_ready_a, out_valid_a, core_rst_a, dm_we_a, busy_a, finished_a, timeout_a;
  logic [7:0] out_data_a, dm_adr_a, dm_di_a, dm_dout_a;
  logic       in_ready_b, out_valid_b, core_rst_b, dm_we_b, busy_b, finished_b, timeout_b;
  logic [7:0] out_data_b, dm_adr_b, dm_di_b, dm_dout_b;
  logic       in_ready_c, out_valid_c, core_rst_c, dm_we_c, busy_c, finished_c, timeout_c;
  logic [7:0] out_data_c, dm_adr_c, dm_di_c;

  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  int         wr_cnt_a = 0;
  logic [7:0] got_a [$];
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  dmem_host_loader #(.LOAD_BASE(8'h00), .LOAD_LEN(32'd4), .DUMP_BASE(8'h80),
                     .DUMP_LEN(32'd2), .TIMEOUT(16'd20)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .core_rst(core_rst_a), .core_done(core_done), .dm_we(dm_we_a),
    .dm_adr(dm_adr_a), .dm_di(dm_di_a), .dm_dout(dm_dout_a), .busy(busy_a),
    .finished(finished_a), .timeout(timeout_a));

  dmem_host_loader #(.LOAD_BASE(8'hFE), .LOAD_LEN(32'd4), .DUMP_BASE(8'hFF),
                     .DUMP_LEN(32'd2), .TIMEOUT(16'd0)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .core_rst(core_rst_b), .core_done(core_done), .dm_we(dm_we_b),
    .dm_adr(dm_adr_b), .dm_di(dm_di_b), .dm_dout(dm_dout_b), .busy(busy_b),
    .finished(finished_b), .timeout(timeout_b));

  dmem_host_loader #(.LOAD_BASE(8'h10), .LOAD_LEN(32'd0), .DUMP_BASE(8'h20),
                     .DUMP_LEN(32'd0), .TIMEOUT(16'd3)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_c), .out_data(out_data_c), .out_valid(out_valid_c),
    .out_ready(out_ready), .core_rst(core_rst_c), .core_done(core_done), .dm_we(dm_we_c),
    .dm_adr(dm_adr_c), .dm_di(dm_di_c), .dm_dout(8'h00), .busy(busy_c),
    .finished(finished_c), .timeout(timeout_c));

  assign dm_dout_a = mem_a[dm_adr_a];
  assign dm_dout_b = mem_b[dm_adr_b];

  // dmem models; mem_a gets its result window preloaded while reset is high.
  always @(posedge clk) begin
    if (reset) begin
      mem_a[8'h80] <= 8'hAA;
      mem_a[8'h81] <= 8'hBB;
    end else if (dm_we_a) begin
      mem_a[dm_adr_a] <= dm_di_a;
      wr_cnt_a <= wr_cnt_a + 1;
    end
    if (dm_we_b) mem_b[dm_adr_b] <= dm_di_b;
    if (out_valid_a && out_ready) got_a.push_back(out_data_a);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat_a(input logic [7:0] b, input logic [7:0] adr);
    in_valid = 1'b1;
    in_data  = b;
    #1;
    check("a_load_we", 16'(dm_we_a), 16'h1);
    check("a_load_adr", 16'(dm_adr_a), 16'(adr));
    check("a_load_di", 16'(dm_di_a), 16'(b));
    tick();
  endtask

  task automatic load_a_b2b();
    for (int i = 0; i < 4; i++) beat_a(8'(8'h50 + i), 8'(i));
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; core_done = 1'b0;
    repeat (3) tick();
    check("rst_core_rst", 16'(core_rst_a), 16'h1);
    check("rst_busy", 16'(busy_a), 16'h0);
    check("rst_in_ready", 16'(in_ready_a), 16'h0);
    check("rst_out_valid", 16'(out_valid_a), 16'h0);
    check("rst_dm_we", 16'(dm_we_a), 16'h0);
    check("rst_dm_adr", 16'(dm_adr_a), 16'h0);
    check("rst_flags", 16'({finished_a, timeout_a}), 16'h0);
    reset = 1'b0;
    tick();

    // Load with idle gaps, then done after 10 RUN cycles, dump with stalls.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("a_load_state", 16'({busy_a, in_ready_a, core_rst_a}), 16'h7);
    for (int i = 0; i < 4; i++) begin
      beat_a(8'(8'h11 * (i + 1)), 8'(i));
      in_valid = 1'b0;
      if (i < 3) begin
        #1;
        check("a_gap_we", 16'(dm_we_a), 16'h0);
        tick();
      end
    end
    check("a_run_core_rst", 16'(core_rst_a), 16'h0);
    check("a_run_in_ready", 16'(in_ready_a), 16'h0);
    check("a_wr_cnt", 16'(wr_cnt_a), 16'd4);
    check("a_mem0", 16'(mem_a[0]), 16'h11);
    check("a_mem1", 16'(mem_a[1]), 16'h22);
    check("a_mem2", 16'(mem_a[2]), 16'h33);
    check("a_mem3", 16'(mem_a[3]), 16'h44);
    repeat (10) tick();
    check("a_run11", 16'({busy_a, core_rst_a, out_valid_a}), 16'h4);
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("a_dump_entry", 16'({out_valid_a, core_rst_a, timeout_a, dm_we_a}), 16'hC);
    check("a_dump_adr0", 16'(dm_adr_a), 16'h80);
    check("a_dump_d0", 16'(out_data_a), 16'hAA);
    tick();
    check("a_stall_d0", 16'(out_data_a), 16'hAA);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("a_dump_adr1", 16'(dm_adr_a), 16'h81);
    check("a_dump_d1", 16'(out_data_a), 16'hBB);
    tick();
    check("a_stall_d1", 16'(out_data_a), 16'hBB);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    check("a_fin", 16'({finished_a, busy_a, timeout_a, out_valid_a, core_rst_a}), 16'h11);
    check("a_got_n", 16'(got_a.size()), 16'd2);
    if (got_a.size() >= 2) begin
      check("a_got0", 16'(got_a[0]), 16'hAA);
      check("a_got1", 16'(got_a[1]), 16'hBB);
    end

    // Timeout after exactly 20 RUN cycles.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("a_fin_cleared", 16'(finished_a), 16'h0);
    load_a_b2b();
    check("a_to_run1", 16'(core_rst_a), 16'h0);
    repeat (19) tick();
    check("a_to_run20", 16'({busy_a, core_rst_a, out_valid_a}), 16'h4);
    tick();
    check("a_to_dump", 16'({out_valid_a, core_rst_a, timeout_a}), 16'h7);
    out_ready = 1'b1; repeat (2) tick(); out_ready = 1'b0;
    check("a_to_fin", 16'({finished_a, timeout_a}), 16'h3);

    // Done and timeout in the same cycle: done wins.
    start_a = 1'b1; tick(); start_a = 1'b0;
    check("a_to_cleared", 16'(timeout_a), 16'h0);
    load_a_b2b();
    repeat (19) tick();
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("a_sim_dump", 16'({out_valid_a, timeout_a}), 16'h2);
    out_ready = 1'b1; repeat (2) tick(); out_ready = 1'b0;
    check("a_sim_fin", 16'({finished_a, timeout_a}), 16'h2);

    // Reset after two load beats, then restart from LOAD_BASE.
    start_a = 1'b1; tick(); start_a = 1'b0;
    beat_a(8'h01, 8'h00);
    beat_a(8'h02, 8'h01);
    in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    check("a_mrst_state", 16'({busy_a, in_ready_a, core_rst_a, out_valid_a}), 16'h2);
    check("a_mrst_flags", 16'({finished_a, timeout_a, dm_we_a}), 16'h0);
    check("a_mrst_adr", 16'(dm_adr_a), 16'h0);
    start_a = 1'b1; tick(); start_a = 1'b0;
    beat_a(8'h5A, 8'h00);
    in_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0; tick();

    // Wrapping load at FE, no timeout, wrapping dump from FF.
    start_b = 1'b1; tick(); start_b = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i + 1);
      #1;
      check("b_wrap_adr", 16'(dm_adr_b), 16'(8'(8'hFE + i)));
      tick();
    end
    in_valid = 1'b0;
    repeat (40) tick();
    check("b_no_timeout", 16'({busy_b, core_rst_b, timeout_b}), 16'h4);
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("b_dump_adr0", 16'(dm_adr_b), 16'hFF);
    check("b_dump_d0", 16'(out_data_b), 16'h02);
    out_ready = 1'b1; tick();
    check("b_dump_adr1", 16'(dm_adr_b), 16'h00);
    check("b_dump_d1", 16'(out_data_b), 16'h03);
    tick(); out_ready = 1'b0;
    check("b_fin", 16'({finished_b, busy_b}), 16'h2);

    // Zero-length load and dump: straight to RUN, straight to FINISH.
    start_c = 1'b1; tick(); start_c = 1'b0;
    check("c_run", 16'({busy_c, core_rst_c, in_ready_c}), 16'h4);
    repeat (2) tick();
    check("c_run3", 16'(busy_c), 16'h1);
    tick();
    check("c_to_fin", 16'({finished_c, timeout_c, busy_c, out_valid_c}), 16'hC);
    start_c = 1'b1; tick(); start_c = 1'b0;
    core_done = 1'b1; tick(); core_done = 1'b0;
    check("c_done_fin", 16'({finished_c, timeout_c}), 16'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
